irq_vector_sequencer: RTL and testbench

- Controller that sequences the CPU memory bus and program counter through the 6502 interrupt and reset entry sequence: push PCH, push PCL, push P, fetch vector low, fetch vector high, load PC.
- Handles reset, NMI, IRQ and BRK with 6502 priority and NMI hijacking.
- Sits beside CU; CU hands the bus to this block at instruction boundaries.

---
 rtl/irq_vector_sequencer.sv | 158 +++++++++++++++
 tb/tb_irq_vector_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/irq_vector_sequencer.sv
// 6502 interrupt/reset entry sequencer: stacks PC and P, fetches the vector and
// hands CU a new PC/SP. Owns the bus from an accepted start until LOAD completes.
module irq_vector_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_boundary,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  input  logic        rdy,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        read,
  output logic        write,
  output logic        busy,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic [7:0]  sp_out,
  output logic        sp_load,
  output logic        set_i
);

  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD} state_t;
  typedef enum logic [1:0] {K_RST, K_NMI, K_BRK, K_IRQ} kind_t;

  state_t      state;
  kind_t       kind;
  kind_t       start_kind;
  logic        nmi_prev, nmi_pending, reset_pending;
  logic [15:0] pc_r, vec_r;
  logic [7:0]  p_r, sp_r, lo_r;

  logic        nmi_edge, irq_req, start, is_rst, push_go, nmi_clr;
  logic [7:0]  sp_dec, p_push;
  logic [15:0] vec_sel;

  always_comb begin
    nmi_edge = ~nmi_n & nmi_prev;
    irq_req  = ~irq_n & ~i_flag;
    start    = reset_pending | (instr_boundary & (nmi_pending | brk_req | irq_req));
    if (reset_pending)    start_kind = K_RST;
    else if (nmi_pending) start_kind = K_NMI;
    else if (brk_req)     start_kind = K_BRK;
    else                  start_kind = K_IRQ;
    is_rst  = (kind == K_RST);
    // Reset "pushes" are dummy reads and so respect rdy; real pushes are writes.
    push_go = ~is_rst | rdy;
    sp_dec  = sp_r - 8'd1;
    p_push  = {p_r[7:6], 1'b1, (kind == K_BRK), p_r[3:0]};
    // A pending NMI hijacks an IRQ/BRK sequence at the vector fetch.
    if (is_rst)           vec_sel = RST_VEC;
    else if (nmi_pending) vec_sel = NMI_VEC;
    else                  vec_sel = IRQ_VEC;
    nmi_clr = (state == PUSH_P) & push_go & ~is_rst & nmi_pending;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      kind          <= K_RST;
      nmi_prev      <= 1'b1;
      nmi_pending   <= 1'b0;
      reset_pending <= 1'b1;
      pc_r          <= '0;
      p_r           <= '0;
      sp_r          <= '0;
      vec_r         <= '0;
      lo_r          <= '0;
      addr          <= '0;
      data_out      <= '0;
      read          <= 1'b0;
      write         <= 1'b0;
      busy          <= 1'b0;
      pc_out        <= '0;
      pc_load       <= 1'b0;
      sp_out        <= '0;
      sp_load       <= 1'b0;
      set_i         <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      // A new edge wins over the clear so it is not lost.
      if (nmi_edge)     nmi_pending <= 1'b1;
      else if (nmi_clr) nmi_pending <= 1'b0;
      pc_load <= 1'b0;
      sp_load <= 1'b0;
      set_i   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= PUSH_PCH;
          kind     <= start_kind;
          pc_r     <= pc_in;
          p_r      <= p_in;
          sp_r     <= sp_in;
          busy     <= 1'b1;
          addr     <= {STACK_PAGE, sp_in};
          read     <= (start_kind == K_RST);
          write    <= (start_kind != K_RST);
          data_out <= (start_kind == K_RST) ? 8'h00 : pc_in[15:8];
        end
        PUSH_PCH: if (push_go) begin
          state    <= PUSH_PCL;
          sp_r     <= sp_dec;
          addr     <= {STACK_PAGE, sp_dec};
          data_out <= is_rst ? 8'h00 : pc_r[7:0];
        end
        PUSH_PCL: if (push_go) begin
          state    <= PUSH_P;
          sp_r     <= sp_dec;
          addr     <= {STACK_PAGE, sp_dec};
          data_out <= is_rst ? 8'h00 : p_push;
        end
        PUSH_P: if (push_go) begin
          state    <= VEC_LO;
          sp_r     <= sp_dec;
          vec_r    <= vec_sel;
          addr     <= vec_sel;
          read     <= 1'b1;
          write    <= 1'b0;
          data_out <= 8'h00;
        end
        VEC_LO: if (rdy) begin
          state <= VEC_HI;
          lo_r  <= data_in;
          addr  <= vec_r + 16'd1;
        end
        VEC_HI: if (rdy) begin
          state   <= LOAD;
          addr    <= '0;
          read    <= 1'b0;
          pc_out  <= {data_in, lo_r};
          sp_out  <= sp_r;
          pc_load <= 1'b1;
          sp_load <= 1'b1;
          set_i   <= 1'b1;
        end
        LOAD: begin
          state  <= IDLE;
          busy   <= 1'b0;
          pc_out <= '0;
          sp_out <= '0;
          if (is_rst) reset_pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_vector_sequencer.sv
// Directed bench for irq_vector_sequencer: bus trace per sequence checked
// against hand-computed stack writes, vector reads and PC/SP results.
module tb_irq_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset, instr_boundary, nmi_n, irq_n, brk_req, i_flag, rdy;
  logic [15:0] pc_in;
  logic [7:0]  p_in, sp_in, data_in;
  logic [15:0] addr, pc_out;
  logic [7:0]  data_out, sp_out;
  logic        read, write, busy, pc_load, sp_load, set_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [24:0] ev [8];
  int          n_ev, busy_n, load_n, load_cyc, hold_n;
  logic        wr_seen, done;
  logic [15:0] pc_got;
  logic [7:0]  sp_got;
  logic [2:0]  pulses;

  always #5 clk = ~clk;

  irq_vector_sequencer dut (
    .clk(clk), .reset(reset), .instr_boundary(instr_boundary), .nmi_n(nmi_n),
    .irq_n(irq_n), .brk_req(brk_req), .i_flag(i_flag), .pc_in(pc_in), .p_in(p_in),
    .sp_in(sp_in), .data_in(data_in), .rdy(rdy), .addr(addr), .data_out(data_out),
    .read(read), .write(write), .busy(busy), .pc_out(pc_out), .pc_load(pc_load),
    .sp_out(sp_out), .sp_load(sp_load), .set_i(set_i)
  );

  // Vector ROM; everything else reads as 00.
  always_comb begin
    case (addr)
      16'hFFFA: data_in = 8'h78;
      16'hFFFB: data_in = 8'h56;
      16'hFFFC: data_in = 8'h34;
      16'hFFFD: data_in = 8'h12;
      16'hFFFE: data_in = 8'hBC;
      16'hFFFF: data_in = 8'h9A;
      default:  data_in = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Follows one sequence from its start edge; records completed bus cycles.
  task automatic run(input int stall_n, input logic [15:0] stall_addr, input int nmi_at);
    int st;
    st = stall_n;
    n_ev = 0; busy_n = 0; load_n = 0; load_cyc = -1; hold_n = 0;
    wr_seen = 0; done = 0; pc_got = '0; sp_got = '0; pulses = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      instr_boundary = 0;
      brk_req = 0;
      if (c == nmi_at) nmi_n = 0;
      if (!busy) begin done = 1; break; end
      busy_n++;
      if (write) wr_seen = 1;
      if (pc_load) begin
        load_n++; load_cyc = c; pc_got = pc_out; sp_got = sp_out;
        pulses = {pc_load, sp_load, set_i};
      end
      if (read && addr == stall_addr) hold_n++;
      if (read && addr == stall_addr && st > 0) begin rdy = 0; st--; end
      else rdy = 1;
      if (((read && rdy) || write) && n_ev < 8) begin
        ev[n_ev] = {write, addr, write ? data_out : 8'h00};
        n_ev++;
      end
    end
    chk("seq_done", done, 1'b1);
  endtask

  initial begin
    reset = 1; instr_boundary = 0; nmi_n = 1; irq_n = 1; brk_req = 0; i_flag = 0;
    rdy = 1; pc_in = '0; p_in = '0; sp_in = '0;
    #2 reset = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ctl", {busy, read, write, pc_load, sp_load, set_i}, 6'b0);
    chk("rst_bus", {addr, data_out}, 24'h0);
    chk("rst_pc_sp", {pc_out, sp_out}, 24'h0);

    // Reset release: dummy stack reads, no writes, vector FFFC.
    reset = 1; sp_in = 8'h00;
    run(0, 16'h0000, -1);
    chk("rs_nev", n_ev, 5);
    chk("rs_ev0", ev[0], {1'b0, 16'h0100, 8'h00});
    chk("rs_ev1", ev[1], {1'b0, 16'h01FF, 8'h00});
    chk("rs_ev2", ev[2], {1'b0, 16'h01FE, 8'h00});
    chk("rs_ev3", ev[3], {1'b0, 16'hFFFC, 8'h00});
    chk("rs_ev4", ev[4], {1'b0, 16'hFFFD, 8'h00});
    chk("rs_wr", wr_seen, 1'b0);
    chk("rs_pc", pc_got, 16'h1234);
    chk("rs_sp", sp_got, 8'hFD);
    chk("rs_pulse", {load_n[3:0], pulses}, {4'd1, 3'b111});
    chk("rs_busy", busy_n, 6);
    chk("rs_lat", load_cyc, 5);

    // IRQ
    pc_in = 16'hC123; p_in = 8'hC3; sp_in = 8'hFF; irq_n = 0; i_flag = 0; instr_boundary = 1;
    run(0, 16'h0000, -1);
    irq_n = 1;
    chk("irq_nev", n_ev, 5);
    chk("irq_ev0", ev[0], {1'b1, 16'h01FF, 8'hC1});
    chk("irq_ev1", ev[1], {1'b1, 16'h01FE, 8'h23});
    chk("irq_ev2", ev[2], {1'b1, 16'h01FD, 8'hE3});
    chk("irq_ev3", ev[3], {1'b0, 16'hFFFE, 8'h00});
    chk("irq_ev4", ev[4], {1'b0, 16'hFFFF, 8'h00});
    chk("irq_pc", pc_got, 16'h9ABC);
    chk("irq_sp", sp_got, 8'hFC);
    chk("irq_busy", busy_n, 6);

    // Masked IRQ
    irq_n = 0; i_flag = 1; instr_boundary = 1;
    run(0, 16'h0000, -1);
    irq_n = 1; i_flag = 0;
    chk("mask_busy", busy_n, 0);
    chk("mask_nev", n_ev, 0);

    // BRK hijacked by NMI falling during PUSH_PCL
    pc_in = 16'h2000; p_in = 8'h00; sp_in = 8'hF0; brk_req = 1; instr_boundary = 1;
    run(0, 16'h0000, 1);
    nmi_n = 1;
    chk("brk_nev", n_ev, 5);
    chk("brk_ev0", ev[0], {1'b1, 16'h01F0, 8'h20});
    chk("brk_ev1", ev[1], {1'b1, 16'h01EF, 8'h00});
    chk("brk_ev2", ev[2], {1'b1, 16'h01EE, 8'h30});
    chk("brk_ev3", ev[3], {1'b0, 16'hFFFA, 8'h00});
    chk("brk_ev4", ev[4], {1'b0, 16'hFFFB, 8'h00});
    chk("brk_pc", pc_got, 16'h5678);
    chk("brk_sp", sp_got, 8'hED);
    instr_boundary = 1;
    run(0, 16'h0000, -1);
    chk("nmi_cleared", busy_n, 0);

    // NMI with three wait states on the vector low read
    nmi_n = 0;
    @(posedge clk); #1;
    nmi_n = 1; pc_in = 16'h4000; p_in = 8'h01; sp_in = 8'h80; instr_boundary = 1;
    run(3, 16'hFFFA, -1);
    chk("nmi_nev", n_ev, 5);
    chk("nmi_ev2", ev[2], {1'b1, 16'h017E, 8'h21});
    chk("nmi_ev3", ev[3], {1'b0, 16'hFFFA, 8'h00});
    chk("nmi_ev4", ev[4], {1'b0, 16'hFFFB, 8'h00});
    chk("nmi_hold", hold_n, 4);
    chk("nmi_lat", load_cyc, 8);
    chk("nmi_pc", pc_got, 16'h5678);
    chk("nmi_sp", sp_got, 8'h7D);

    // Reset asserted during PUSH_P of an IRQ
    pc_in = 16'h1111; p_in = 8'h00; sp_in = 8'hFF; irq_n = 0; instr_boundary = 1;
    @(posedge clk); #1;
    instr_boundary = 0; irq_n = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_pushp", {write, addr, data_out}, {1'b1, 16'h01FD, 8'h20});
    #2 reset = 0;
    #1;
    chk("mid_ctl", {busy, read, write, pc_load, sp_load, set_i}, 6'b0);
    chk("mid_bus", {addr, data_out}, 24'h0);
    @(posedge clk); #1;
    sp_in = 8'h00; reset = 1;
    run(0, 16'h0000, -1);
    chk("rs2_nev", n_ev, 5);
    chk("rs2_ev0", ev[0], {1'b0, 16'h0100, 8'h00});
    chk("rs2_ev3", ev[3], {1'b0, 16'hFFFC, 8'h00});
    chk("rs2_wr", wr_seen, 1'b0);
    chk("rs2_pc", pc_got, 16'h1234);
    chk("rs2_sp", sp_got, 8'hFD);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
